// File: rtl/spi3w_cfg_responder.sv
// 3-wire SPI configuration responder: 16-bit instruction then data bytes, addresses counting down.
// Oversamples SCLK/CSB/SDIO on clk. Read support is built only when SPI_READ_EN is defined.
module spi3w_cfg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_csb,
  input  logic              spi_sclk,
  input  logic              spi_sdio_i,
  output logic              spi_sdio_o,
  output logic              spi_sdio_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INSTR = 3'd1,
    S_WDATA = 3'd2,
`ifdef SPI_READ_EN
    S_RDATA = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csb_sync, r_sdio_sync;
  logic                   r_sclk_prev, r_csb_prev;
  logic                   w_sclk, w_csb, w_sdio;
  logic                   w_sclk_rise, w_csb_rise, w_csb_fall;

  state_t            r_state, w_state_n;
  logic [3:0]        r_bit_cnt, w_bit_cnt_n;
  logic [14:0]       r_shift, w_shift_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [1:0]        r_left, w_left_n;
  logic              r_stream, w_stream_n;
  logic              r_wr, w_wr_n;
  logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_n;
  logic [7:0]        r_wdata, w_wdata_n;
  logic [15:0]       w_instr;

`ifdef SPI_READ_EN
  logic       w_sclk_fall;
  logic       r_rd, w_rd_n;
  logic       r_load;
  logic [7:0] r_tx, w_tx_n;
  logic [2:0] r_tx_cnt, w_tx_cnt_n;
  logic       r_oe, w_oe_n;
  logic       r_sdo, w_sdo_n;
`endif

  // CSB/SCLK chains reset to 0 so a reset with CSB held low never looks like a CSB falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_csb_sync  <= '0;
      r_sdio_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_csb_prev  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb};
      r_sdio_sync <= {r_sdio_sync[SYNC_STAGES-2:0], spi_sdio_i};
      r_sclk_prev <= w_sclk;
      r_csb_prev  <= w_csb;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb       = r_csb_sync[SYNC_STAGES-1];
  assign w_sdio      = r_sdio_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_csb_rise  = w_csb & ~r_csb_prev;
  assign w_csb_fall  = ~w_csb & r_csb_prev;
  assign w_instr     = {r_shift, w_sdio};
`ifdef SPI_READ_EN
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_bit_cnt_n  = r_bit_cnt;
    w_shift_n    = r_shift;
    w_addr_n     = r_addr;
    w_left_n     = r_left;
    w_stream_n   = r_stream;
    w_wr_n       = 1'b0;
    w_reg_addr_n = r_reg_addr;
    w_wdata_n    = r_wdata;
`ifdef SPI_READ_EN
    w_rd_n       = 1'b0;
    w_tx_n       = r_tx;
    w_tx_cnt_n   = r_tx_cnt;
    w_oe_n       = r_oe;
    w_sdo_n      = r_sdo;
    if (r_load) w_tx_n = reg_rdata;
`endif
    // CSB release wins over any SCLK edge seen in the same sample.
    if (w_csb_rise) begin
      w_state_n = S_IDLE;
`ifdef SPI_READ_EN
      w_oe_n    = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_csb_fall) begin
            w_state_n   = S_INSTR;
            w_bit_cnt_n = 4'd0;
            w_shift_n   = '0;
          end
        end
        S_INSTR: begin
          if (w_sclk_rise) begin
            w_shift_n   = {r_shift[13:0], w_sdio};
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) begin
              w_bit_cnt_n = 4'd0;
              w_addr_n    = w_instr[ADDR_W-1:0];
              w_left_n    = w_instr[14:13];
              w_stream_n  = &w_instr[14:13];
              if (w_instr[15]) begin
`ifdef SPI_READ_EN
                w_state_n    = S_RDATA;
                w_rd_n       = 1'b1;
                w_reg_addr_n = w_instr[ADDR_W-1:0];
                w_tx_cnt_n   = 3'd0;
`else
                w_state_n    = S_DONE;
`endif
              end else begin
                w_state_n = S_WDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (w_sclk_rise) begin
            w_shift_n   = {r_shift[13:0], w_sdio};
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt[2:0] == 3'd7) begin
              w_bit_cnt_n  = 4'd0;
              w_wr_n       = 1'b1;
              w_reg_addr_n = r_addr;
              w_wdata_n    = {r_shift[6:0], w_sdio};
              w_addr_n     = r_addr - ADDR_W'(1);
              if (!r_stream && r_left == 2'd0) w_state_n = S_DONE;
              else if (!r_stream) w_left_n = r_left - 2'd1;
            end
          end
        end
`ifdef SPI_READ_EN
        S_RDATA: begin
          if (w_sclk_fall) begin
            w_oe_n     = 1'b1;
            w_sdo_n    = r_tx[7];
            w_tx_n     = {r_tx[6:0], 1'b0};
            w_tx_cnt_n = r_tx_cnt + 3'd1;
            // Last bit of this byte is now on the wire: fetch the next byte early.
            if (r_tx_cnt == 3'd7 && (r_stream || r_left != 2'd0)) begin
              w_addr_n     = r_addr - ADDR_W'(1);
              w_reg_addr_n = r_addr - ADDR_W'(1);
              w_rd_n       = 1'b1;
            end
          end else if (w_sclk_rise) begin
            w_bit_cnt_n = r_bit_cnt + 4'd1;
            if (r_bit_cnt[2:0] == 3'd7) begin
              w_bit_cnt_n = 4'd0;
              if (!r_stream && r_left == 2'd0) begin
                w_state_n = S_DONE;
                w_oe_n    = 1'b0;
              end else if (!r_stream) begin
                w_left_n = r_left - 2'd1;
              end
            end
          end
        end
`endif
        S_DONE: begin
`ifdef SPI_READ_EN
          w_oe_n = 1'b0;
`endif
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_left     <= 2'd0;
      r_stream   <= 1'b0;
      r_wr       <= 1'b0;
      r_reg_addr <= '0;
      r_wdata    <= 8'd0;
`ifdef SPI_READ_EN
      r_rd       <= 1'b0;
      r_load     <= 1'b0;
      r_tx       <= 8'd0;
      r_tx_cnt   <= 3'd0;
      r_oe       <= 1'b0;
      r_sdo      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_shift    <= w_shift_n;
      r_addr     <= w_addr_n;
      r_left     <= w_left_n;
      r_stream   <= w_stream_n;
      r_wr       <= w_wr_n;
      r_reg_addr <= w_reg_addr_n;
      r_wdata    <= w_wdata_n;
`ifdef SPI_READ_EN
      r_rd       <= w_rd_n;
      r_load     <= r_rd;
      r_tx       <= w_tx_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_oe       <= w_oe_n;
      r_sdo      <= w_sdo_n;
`endif
    end
  end

  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr    = r_wr;
  assign busy      = (r_state != S_IDLE);

`ifdef SPI_READ_EN
  assign reg_rd      = r_rd;
  assign spi_sdio_oe = r_oe;
  assign spi_sdio_o  = r_sdo;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^reg_rdata;
  assign reg_rd         = 1'b0;
  assign spi_sdio_oe    = 1'b0;
  assign spi_sdio_o     = 1'b0;
`endif

endmodule
